// File: rtl/cpu_sram_bridge.sv
// Bridges one sram-like core channel (req/addr_ok/data_ok) onto a synchronous SRAM port.
// Define BRIDGE_RDATA_BYPASS_EN to return read data combinationally in cycle T+SRAM_LAT.
module cpu_sram_bridge #(
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic        rd_q;
  logic [31:0] rdata_q;
  logic        last_cycle;
  logic        can_accept;
  logic [3:0]  wen_raw;
  logic [31:0] wdata_rep;

  assign last_cycle = (state == WAIT) && (cnt == 2'd1);

`ifdef BRIDGE_RDATA_BYPASS_EN
  // Response cycle doubles as the next accept slot, so streams run at one per SRAM_LAT.
  assign can_accept  = (state == IDLE) || last_cycle;
  assign cpu_data_ok = last_cycle && !rst;
  assign cpu_rdata   = (cpu_data_ok && rd_q) ? sram_rdata : rdata_q;
`else
  assign can_accept  = (state == IDLE) || (state == RESP);
  assign cpu_data_ok = (state == RESP) && !rst;
  assign cpu_rdata   = rdata_q;
`endif

  assign cpu_addr_ok = cpu_req && !rst && can_accept;
  assign sram_en     = cpu_addr_ok;
  assign sram_addr   = cpu_addr;
  assign sram_wdata  = wdata_rep;
  assign sram_wen    = (cpu_addr_ok && cpu_wr) ? wen_raw : '0;

  // Misaligned and reserved sizes leave every lane disabled but still complete normally.
  always_comb begin
    wen_raw   = '0;
    wdata_rep = cpu_wdata;
    case (cpu_size)
      2'd0: begin
        wen_raw   = 4'b0001 << cpu_addr[1:0];
        wdata_rep = {4{cpu_wdata[7:0]}};
      end
      2'd1: begin
        wen_raw   = cpu_addr[0] ? 4'b0000 : (cpu_addr[1] ? 4'b1100 : 4'b0011);
        wdata_rep = {2{cpu_wdata[15:0]}};
      end
      2'd2: begin
        wen_raw   = (cpu_addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
        wdata_rep = cpu_wdata;
      end
      default: begin
        wen_raw   = '0;
        wdata_rep = cpu_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (last_cycle && rd_q)
        rdata_q <= sram_rdata;
      if (cpu_addr_ok) begin
        state <= WAIT;
        cnt   <= 2'(SRAM_LAT);
        rd_q  <= !cpu_wr;
      end else begin
        case (state)
          WAIT: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
`ifdef BRIDGE_RDATA_BYPASS_EN
              state <= IDLE;
`else
              state <= RESP;
`endif
            end
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Randomized bench for cpu_sram_bridge: an SRAM model plus a cycle-count reference of the
// accept/response schedule and memory contents.
module tb_cpu_sram_bridge;

  localparam int unsigned LAT = 1;
`ifdef BRIDGE_RDATA_BYPASS_EN
  localparam int unsigned RESP_DLY = LAT;
`else
  localparam int unsigned RESP_DLY = LAT + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  cpu_sram_bridge #(.SRAM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata), .sram_en(sram_en),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: read data emerges LAT cycles after the enable cycle.
  logic [31:0] mem [16];
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    if (sram_en) begin
      pipe[0] <= mem[sram_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end
  assign sram_rdata = pipe[LAT-1];

  typedef struct {
    int unsigned due;
    bit          rd;
    logic [31:0] word;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rdata = '0;
  int unsigned cyc = 0;
  int unsigned next_ok = 0;
  bit          after_rst = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [31:0] addr);
    int unsigned nb;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    if (nb == 0 || (addr % nb) != 0) return 4'b0000;
    return 4'(((1 << nb) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return {24'b0, wd[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'b0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  bit          edok, eaok;
  logic [3:0]  emask;
  logic [31:0] bmask, rep;

  // Reference: accept allowed RESP_DLY cycles after the previous accept; one response each.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      last_rdata = '0;
      next_ok    = 0;
      after_rst  = 1'b1;
      check("addr_ok_in_rst", cpu_addr_ok, 0);
      check("data_ok_in_rst", cpu_data_ok, 0);
    end else begin
      if (after_rst) begin
        check("rdata_after_rst", cpu_rdata, 32'h0);
        after_rst = 1'b0;
      end
      edok = (pend.size() > 0) && (pend[0].due == cyc);
      check("data_ok", cpu_data_ok, edok);
      if (edok) begin
        if (pend[0].rd) last_rdata = pend[0].word;
        check("rdata", cpu_rdata, last_rdata);
        void'(pend.pop_front());
      end
      eaok = cpu_req && (cyc >= next_ok);
      check("addr_ok", cpu_addr_ok, eaok);
      check("sram_en", sram_en, eaok);
      emask = (eaok && cpu_wr) ? lane_mask(cpu_size, cpu_addr) : 4'b0000;
      check("sram_wen", sram_wen, emask);
      if (eaok) begin
        check("sram_addr", sram_addr, cpu_addr);
        if (emask != 4'b0000) begin
          rep = replicate(cpu_size, cpu_wdata);
          check("sram_wdata", sram_wdata, rep);
          bmask = '0;
          for (int b = 0; b < 4; b++) if (emask[b]) bmask[8*b +: 8] = 8'hFF;
          ref_mem[cpu_addr[5:2]] = (ref_mem[cpu_addr[5:2]] & ~bmask) | (rep & bmask);
        end
        pend.push_back('{due: cyc + RESP_DLY, rd: !cpu_wr, word: ref_mem[cpu_addr[5:2]]});
        next_ok = cyc + RESP_DLY;
      end
    end
    cyc++;
  end

  task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd);
    int unsigned waited;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = wd;
    waited = 0;
    @(negedge clk);
    while (!cpu_addr_ok && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!cpu_addr_ok) check("accept_timeout", 32'(waited), 32'd0);
  endtask

  task automatic idle(input int unsigned n);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [1:0]  rsz;
  logic [31:0] raddr;
  int unsigned rsel;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'hDEAD_BEEF;
    ref_mem[0] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Aligned word read, then byte/half/misaligned writes.
    issue(1'b0, 2'd2, 32'h1000, 32'h0);
    check("t1_en", sram_en, 1);
    check("t1_wen", sram_wen, 4'b0000);
    idle(3);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    issue(1'b1, 2'd0, 32'h1003, 32'h0000_00A5);
    check("t2_wen", sram_wen, 4'b1000);
    check("t2_wdata", sram_wdata, 32'hA5A5_A5A5);
    idle(2);
    issue(1'b1, 2'd1, 32'h1002, 32'h0000_1234);
    check("t3_wen", sram_wen, 4'b1100);
    check("t3_wdata", sram_wdata, 32'h1234_1234);
    issue(1'b1, 2'd2, 32'h1001, 32'hFFFF_FFFF);
    check("t3_misaligned_wen", sram_wen, 4'b0000);
    issue(1'b0, 2'd2, 32'h1000, 32'h0);
    idle(3);
    check("t3_merged_word", cpu_rdata, 32'h1234_BEEF);

    // Back-to-back reads with req held.
    issue(1'b0, 2'd2, 32'h1004, 32'h0);
    issue(1'b0, 2'd2, 32'h1008, 32'h0);
    issue(1'b0, 2'd2, 32'h100C, 32'h0);
    idle(3);

    // Reset one cycle after accept; a fresh request is accepted as rst drops.
    issue(1'b0, 2'd2, 32'h1010, 32'h0);
    pulse_rst();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1014;
    @(negedge clk);
    check("t5_reaccept", cpu_addr_ok, 1);
    idle(3);

    // Streamed reads.
    for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'h1000 + 32'(4 * i), 32'h0);
    idle(3);

    repeat (400) begin
      rsel = $urandom_range(0, 9);
      rsz  = (rsel < 3) ? 2'd0 : (rsel < 6) ? 2'd1 : (rsel < 9) ? 2'd2 : 2'd3;
      raddr = 32'h1000 | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0) begin
        if (rsz == 2'd1) raddr[0] = 1'b0;
        if (rsz == 2'd2) raddr[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), rsz, raddr, $urandom);
      if ($urandom_range(0, 49) == 0) pulse_rst();
      else if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(5);
    check("no_pending_resp", 32'(pend.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
